// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ds_pkg
// Brief   : Shared constants, sample type and helpers for the decimators.
// Revision: 1.0
// ============================================================================
package ds_pkg;

  localparam int DS_WIDTH_DEFAULT  = 10;
  localparam int DS_FACTOR_DEFAULT = 4;
  localparam int DS_MODE_PICK      = 0;
  localparam int DS_MODE_AVG       = 1;

  // Default-width sample; width-specific variants come from down_sampler_if.
  typedef logic signed [DS_WIDTH_DEFAULT-1:0] ds_sample_t;

  function automatic bit ds_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/down_sampler_if.sv
`default_nettype none
// ============================================================================
// Module  : down_sampler_if
// Brief   : Sample stream in / decimated strobe out for the down_sampler.
// Revision: 1.0
// ============================================================================
interface down_sampler_if
  import ds_pkg::*;
#(
  parameter int WIDTH = DS_WIDTH_DEFAULT
) ();

  typedef logic signed [WIDTH-1:0] sample_t;

  logic    en;
  sample_t data_in;
  sample_t data_out;
  logic    valid_out;

  modport master (
    output en,
    output data_in,
    input  data_out,
    input  valid_out
  );

  modport slave (
    input  en,
    input  data_in,
    output data_out,
    output valid_out
  );

endinterface
`default_nettype wire

// File: rtl/ds_phase_counter.sv
`default_nettype none
// ============================================================================
// Module  : ds_phase_counter
// Brief   : Modulo-FACTOR phase counter flagging the last sample of a group.
// Revision: 1.0
// ============================================================================
module ds_phase_counter #(
  parameter  int FACTOR = 4,
  localparam int PW     = $clog2(FACTOR)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          en,
  output logic      [PW-1:0] phase,
  output logic               last
);

  logic [PW-1:0] r_phase_q;
  logic [PW-1:0] w_phase_d;

  assign phase = r_phase_q;
  assign last  = en && (r_phase_q == PW'(FACTOR - 1));

  always_comb begin
    w_phase_d = r_phase_q;
    if (en) begin
      w_phase_d = last ? '0 : r_phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase_q <= '0;
    end else begin
      r_phase_q <= w_phase_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/down_sampler.sv
`default_nettype none
// ============================================================================
// Module  : down_sampler
// Brief   : Decimate by FACTOR, emitting the last sample or the group mean.
// Revision: 1.0
// ============================================================================
module down_sampler
  import ds_pkg::*;
#(
  parameter int WIDTH    = DS_WIDTH_DEFAULT,
  parameter int FACTOR   = DS_FACTOR_DEFAULT,
  parameter int AVG_MODE = DS_MODE_PICK
) (
  input wire logic       clk,
  input wire logic       rst,
  down_sampler_if.slave  bus
);

  localparam int PW = $clog2(FACTOR);
  localparam int AW = WIDTH + PW;

  generate
    if (FACTOR < 2 || !ds_is_pow2(FACTOR)) begin : g_bad_factor
      $error("down_sampler: FACTOR must be a power of two >= 2");
    end
  endgenerate

  logic [PW-1:0]          w_phase;
  logic                   w_last;
  logic signed [AW-1:0]   r_acc_q,  w_acc_d;
  logic signed [AW-1:0]   w_acc_base;
  logic signed [AW-1:0]   w_sum;
  logic signed [WIDTH-1:0] w_avg;
  logic signed [WIDTH-1:0] r_data_q, w_data_d;
  logic                   r_valid_q, w_valid_d;

  ds_phase_counter #(
    .FACTOR (FACTOR)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .phase (w_phase),
    .last  (w_last)
  );

  always_comb begin
    // Phase 0 starts a fresh group regardless of any stale accumulator value.
    w_acc_base = (w_phase == '0) ? '0 : r_acc_q;
    w_sum      = w_acc_base + AW'(bus.data_in);
    w_avg      = WIDTH'(w_sum >>> PW);

    w_acc_d   = r_acc_q;
    w_data_d  = r_data_q;
    w_valid_d = 1'b0;
    if (bus.en) begin
      if (w_last) begin
        w_acc_d   = '0;
        w_data_d  = (AVG_MODE != DS_MODE_PICK) ? w_avg : bus.data_in;
        w_valid_d = 1'b1;
      end else begin
        w_acc_d = w_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_q   <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_acc_q   <= w_acc_d;
      r_data_q  <= w_data_d;
      r_valid_q <= w_valid_d;
    end
  end

  assign bus.data_out  = r_data_q;
  assign bus.valid_out = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_down_sampler.sv
`default_nettype none
// ============================================================================
// Module  : tb_down_sampler
// Brief   : Directed bench driving pick and average instances side by side.
// Revision: 1.0
// ============================================================================
module tb_down_sampler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   hp;
  int   ha;
  int   pulses;

  down_sampler_if #(.WIDTH(10)) ifp ();
  down_sampler_if #(.WIDTH(10)) ifa ();

  down_sampler #(.WIDTH(10), .FACTOR(4), .AVG_MODE(0)) u_pick (
    .clk (clk),
    .rst (rst),
    .bus (ifp.slave)
  );

  down_sampler #(.WIDTH(10), .FACTOR(4), .AVG_MODE(1)) u_avg (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic signed [9:0] obs, input int exp);
    logic signed [9:0] e;
    e = 10'(exp);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  // Drive one cycle on both instances, then check strobe and held/new outputs.
  task automatic cyc(input logic r, input logic e, input int d,
                     input logic v, input int p, input int a, input string tag);
    @(negedge clk);
    rst         = r;
    ifp.en      = e;
    ifa.en      = e;
    ifp.data_in = 10'(d);
    ifa.data_in = 10'(d);
    @(posedge clk);
    #1;
    if (ifp.valid_out === 1'b1) pulses++;
    chk_bit ({tag, "_pick_valid"}, ifp.valid_out, v);
    chk_bit ({tag, "_avg_valid"},  ifa.valid_out, v);
    chk_data({tag, "_pick_data"},  ifp.data_out,  p);
    chk_data({tag, "_avg_data"},   ifa.data_out,  a);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    hp     = 0;
    ha     = 0;
    rst         = 1'b1;
    ifp.en      = 1'b1;
    ifa.en      = 1'b1;
    ifp.data_in = 10'd123;
    ifa.data_in = 10'd123;

    // Reset held with enable active and a nonzero sample
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 123, 1'b0, 0, 0, "reset");

    // Ramp 0..19: strobes on every 4th sample, mean of 4g..4g+3 floors to 4g+1
    for (int i = 0; i < 20; i++) begin
      logic v;
      v = ((i % 4) == 3);
      if (v) begin
        hp = i;
        ha = i - 2;
      end
      cyc(1'b0, 1'b1, i, v, hp, ha, "ramp");
    end
    chk_data("ramp_pulse_count", 10'(pulses), 5);

    // Negative group: sum -10, arithmetic shift floors -2.5 to -3
    cyc(1'b0, 1'b1, -1, 1'b0, 19, 17, "neg");
    cyc(1'b0, 1'b1, -2, 1'b0, 19, 17, "neg");
    cyc(1'b0, 1'b1, -3, 1'b0, 19, 17, "neg");
    cyc(1'b0, 1'b1, -4, 1'b1, -4, -3, "neg");

    // Enable gating resumes a partial group
    cyc(1'b0, 1'b1, 0,  1'b0, -4, -3, "gate");
    cyc(1'b0, 1'b1, 1,  1'b0, -4, -3, "gate");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 99, 1'b0, -4, -3, "gate_off");
    cyc(1'b0, 1'b1, 2,  1'b0, -4, -3, "gate");
    cyc(1'b0, 1'b1, 3,  1'b1,  3,  1, "gate_strobe");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, -77, 1'b0, 3, 1, "gate_hold");

    // Reset mid-group discards 10 and 20
    cyc(1'b0, 1'b1, 10, 1'b0, 3, 1, "midrst");
    cyc(1'b0, 1'b1, 20, 1'b0, 3, 1, "midrst");
    cyc(1'b1, 1'b1, 30, 1'b0, 0, 0, "midrst_rst");
    cyc(1'b0, 1'b1, 1,  1'b0, 0, 0, "midrst");
    cyc(1'b0, 1'b1, 2,  1'b0, 0, 0, "midrst");
    cyc(1'b0, 1'b1, 3,  1'b0, 0, 0, "midrst");
    cyc(1'b0, 1'b1, 4,  1'b1, 4, 2, "midrst_strobe");

    // Extremes at full scale
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, -512, 1'b0, 4, 2, "ext_min");
    cyc(1'b0, 1'b1, -512, 1'b1, -512, -512, "ext_min_strobe");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 511, 1'b0, -512, -512, "ext_max");
    cyc(1'b0, 1'b1, 511, 1'b1, 511, 511, "ext_max_strobe");
    cyc(1'b0, 1'b1,  511, 1'b0, 511, 511, "ext_alt");
    cyc(1'b0, 1'b1, -512, 1'b0, 511, 511, "ext_alt");
    cyc(1'b0, 1'b1,  511, 1'b0, 511, 511, "ext_alt");
    cyc(1'b0, 1'b1, -512, 1'b1, -512, -1, "ext_alt_strobe");
    cyc(1'b0, 1'b0, 0,    1'b0, -512, -1, "ext_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
